// File: rtl/aes128_round_ctrl_pkg.sv
// Shared AES-128 definitions: round count, FSM encoding, S-box table,
// Rcon lookup and the byte-level round transforms used by the datapath.
// Byte s(r,c) of a 128-bit block lives at bits [127-8*(4c+r) -: 8].
package aes128_round_ctrl_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_LAST  = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // MSB position of state byte s(r,c) in the column-major block.
  function automatic int byte_msb(input int r, input int c);
    return 127 - 8 * (4 * c + r);
  endfunction

  // Round constant for key expansion; rounds outside 1..10 yield zero.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    logic [7:0] v;
    case (rnd)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[2047 - 8 * int'(b) -: 8];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[byte_msb(r, c) -: 8] = s[byte_msb(r, (c + r) % 4) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[byte_msb(0, c) -: 8];
      a1 = s[byte_msb(1, c) -: 8];
      a2 = s[byte_msb(2, c) -: 8];
      a3 = s[byte_msb(3, c) -: 8];
      o[byte_msb(0, c) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[byte_msb(1, c) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[byte_msb(2, c) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[byte_msb(3, c) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes128_round_ctrl_key_step.sv
// Combinational AES-128 key expansion step: derives the next round key
// from the current one and the round's Rcon byte.
module aes128_round_ctrl_key_step
  import aes128_round_ctrl_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon_in,
  output logic [127:0] key_out
);

  logic [31:0] w_in  [4];
  logic [31:0] w_out [4];
  logic [31:0] rot_w;
  logic [31:0] sub_w;
  logic [31:0] temp_w;

  // Word 0 is the most significant 32 bits.
  for (genvar gi = 0; gi < 4; gi++) begin : g_split
    assign w_in[gi] = key_in[127 - 32*gi -: 32];
  end

  // RotWord then SubWord on the last word, with Rcon folded into the top byte.
  assign rot_w = {w_in[3][23:0], w_in[3][31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_subword
    assign sub_w[8*gi +: 8] = sbox(rot_w[8*gi +: 8]);
  end

  assign temp_w   = sub_w ^ {rcon_in, 24'h000000};
  assign w_out[0] = w_in[0] ^ temp_w;

  for (genvar gi = 1; gi < 4; gi++) begin : g_chain
    assign w_out[gi] = w_in[gi] ^ w_out[gi-1];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_join
    assign key_out[127 - 32*gi -: 32] = w_out[gi];
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per clock, round keys
// generated on the fly, valid/ready handshake on both block interfaces.
module aes128_round_ctrl
  import aes128_round_ctrl_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int DATA_W = AES_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] plaintext,
  input  logic [DATA_W-1:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ciphertext,
  output logic              busy,
  output logic [3:0]        round
);

  localparam logic [3:0] MAX_ROUND       = 4'(NR);
  localparam logic [3:0] LAST_MAIN_ROUND = 4'(NR - 1);

  aes_state_e        fsm_q, fsm_d;
  logic [DATA_W-1:0] state_q, state_d;
  logic [DATA_W-1:0] rkey_q, rkey_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic [3:0]        round_q, round_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DATA_W-1:0] sb_w, sr_w, mc_w, mix_w, nk_w, rnd_out_w;

  // Round datapath; MixColumns is bypassed in the final round.
  assign sb_w      = sub_bytes(state_q);
  assign sr_w      = shift_rows(sb_w);
  assign mc_w      = mix_columns(sr_w);
  assign mix_w     = (fsm_q == ST_LAST) ? sr_w : mc_w;
  assign rnd_out_w = mix_w ^ nk_w;

  aes128_round_ctrl_key_step u_key_step (
    .key_in  (rkey_q),
    .rcon_in (rcon(round_q)),
    .key_out (nk_w)
  );

  // Next-state and register-update logic for the round sequencer.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    ct_d        = ct_q;
    round_d     = round_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (fsm_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = plaintext ^ key;
          rkey_d     = key;
          round_d    = 4'd1;
          in_ready_d = 1'b0;
          fsm_d      = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = rnd_out_w;
        rkey_d  = nk_w;
        round_d = (round_q < MAX_ROUND) ? round_q + 4'd1 : round_q;
        if (round_q == LAST_MAIN_ROUND) begin
          fsm_d = ST_LAST;
        end
      end
      ST_LAST: begin
        state_d     = rnd_out_w;
        rkey_d      = nk_w;
        ct_d        = rnd_out_w;
        out_valid_d = 1'b1;
        fsm_d       = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          round_d     = 4'd0;
          in_ready_d  = 1'b1;
          fsm_d       = ST_IDLE;
        end
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any block in flight without an output pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      rkey_q      <= '0;
      ct_q        <= '0;
      round_q     <= 4'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      ct_q        <= ct_d;
      round_q     <= round_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign ciphertext = ct_q;
  assign round      = round_q;
  assign busy       = (fsm_q == ST_ROUND) || (fsm_q == ST_LAST);

  round_le_nr_a: assert property (@(posedge clk) disable iff (!rst_n) round_q <= MAX_ROUND);

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Directed bench for aes128_round_ctrl using FIPS-197 known-answer vectors
// and an expected-ciphertext scoreboard.
module tb_aes128_round_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;
  logic [3:0]   round;

  always #5 clk = ~clk;

  aes128_round_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .plaintext  (plaintext),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ciphertext (ciphertext),
    .busy       (busy),
    .round      (round)
  );

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] S1_ARK = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] S1_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] K3     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P3     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C3     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int           n_cmp = 0;
  int           n_err = 0;
  int           n_out = 0;
  int           since_acc = 0;
  logic [127:0] cur_exp;
  logic [127:0] exp_q [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected round counter k clocks after accept (accept edge is clock 1).
  function automatic logic [3:0] exp_round(input int k);
    if (k >= 12) return 4'd0;
    if (k >= 10) return 4'd10;
    return 4'(k);
  endfunction

  // Called at a falling edge with inputs set up; scores what the next rising edge does.
  task automatic step(output bit acc);
    logic [127:0] exp_ct;
    acc = (in_valid === 1'b1) && (in_ready === 1'b1);
    if ((out_valid === 1'b1) && (out_ready === 1'b1)) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 128'(out_valid), 128'd0);
      end else begin
        exp_ct = exp_q.pop_front();
        $display("out   #%0d ct=%h exp=%h", n_out, ciphertext, exp_ct);
        check("ciphertext", ciphertext, exp_ct);
      end
    end
    if (acc) begin
      exp_q.push_back(cur_exp);
      since_acc = 0;
      $display("accept pt=%h key=%h", plaintext, key);
    end
    @(negedge clk);
    since_acc++;
  endtask

  // One block with full per-clock trace of round, busy and out_valid.
  task automatic run_traced(input logic [127:0] pt, input logic [127:0] k_in,
                            input logic [127:0] ct, input bit probe);
    bit acc;
    plaintext = pt;
    key       = k_in;
    cur_exp   = ct;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("in_ready_idle", 128'(in_ready), 128'd1);
    step(acc);
    in_valid = 1'b0;
    check("accepted", 128'(acc), 128'd1);
    for (int k = 1; k <= 11; k++) begin
      check("round_trace", 128'(round), 128'(exp_round(k)));
      check("out_valid_latency", 128'(out_valid), 128'(k == 11));
      check("busy", 128'(busy), 128'(k <= 10));
      if (probe && k == 1) begin
        check("ark0_state", dut.state_q, S1_ARK);
        check("mixcol_in_r1", dut.sr_w, S1_SR);
      end
      step(acc);
    end
    check("in_ready_after", 128'(in_ready), 128'd1);
    check("out_valid_after", 128'(out_valid), 128'd0);
    check("round_after", 128'(round), 128'd0);
    check("ct_held", ciphertext, ct);
    check("scoreboard_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    bit acc;
    int n_acc;
    int n_out_start;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    cur_exp   = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_round", 128'(round), 128'd0);
    check("rst_ct", ciphertext, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // App. B vector with latency, trace and internal probes
    run_traced(P1, K1, C1, 1'b1);

    // App. C.1 vector
    run_traced(P3, K3, C3, 1'b0);

    // Back-pressure: hold the result for 20 clocks while in_valid pulses
    out_ready = 1'b0;
    plaintext = P1;
    key       = K1;
    cur_exp   = C1;
    in_valid  = 1'b1;
    step(acc);
    in_valid = 1'b0;
    for (int k = 1; k <= 10; k++) step(acc);
    plaintext = P3;
    key       = K3;
    cur_exp   = C3;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ct_stable", ciphertext, C1);
      check("bp_in_ready", 128'(in_ready), 128'd0);
      step(acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step(acc);
    check("bp_release_in_ready", 128'(in_ready), 128'd1);
    check("bp_release_out_valid", 128'(out_valid), 128'd0);
    run_traced(P3, K3, C3, 1'b0);

    // Reset in the middle of round 5
    plaintext = P1;
    key       = K1;
    cur_exp   = C1;
    in_valid  = 1'b1;
    step(acc);
    in_valid = 1'b0;
    for (int k = 1; k < 5; k++) step(acc);
    check("pre_reset_round", 128'(round), 128'd5);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_in_ready", 128'(in_ready), 128'd1);
    check("mid_rst_out_valid", 128'(out_valid), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_round", 128'(round), 128'd0);
    check("mid_rst_ct", ciphertext, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_traced(P3, K3, C3, 1'b0);

    // Back-to-back: in_valid held high across two queued vectors
    out_ready   = 1'b1;
    plaintext   = P1;
    key         = K1;
    cur_exp     = C1;
    in_valid    = 1'b1;
    n_acc       = 0;
    n_out_start = n_out;
    for (int cyc = 0; cyc < 40 && (n_out - n_out_start) < 2; cyc++) begin
      if (n_acc > 0) check("b2b_round", 128'(round), 128'(exp_round(since_acc)));
      step(acc);
      if (acc) begin
        n_acc++;
        if (n_acc == 1) begin
          plaintext = P3;
          key       = K3;
          cur_exp   = C3;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_outputs", 128'(n_out - n_out_start), 128'd2);
    check("b2b_scoreboard_empty", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
